// File: rtl/pipe_stage_chain_pkg.sv
// pipe_stage_chain_pkg: shared CPU datapath widths and a small popcount helper.
package pipe_stage_chain_pkg;
  localparam int PC_W = 16;
  localparam int MAX_DEPTH = 8;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 += {3'd0, v[i]};
  endfunction
endpackage

// File: rtl/pipe_stage_chain_pipe_stage.sv
// pipe_stage: one pipeline register stage with flush-to-bubble and stall hold.
module pipe_stage
  import pipe_stage_chain_pkg::*;
#(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              src_valid,
  input  logic [CTRL_W-1:0] src_ctrl,
  input  logic [DATA_W-1:0] src_data,
  input  logic [PC_W-1:0]   src_pc,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data,
  output logic [PC_W-1:0]   pc,
  output logic              killed
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
      pc    <= '0;
    end else begin
      valid <= !flush && (stall ? valid : src_valid);
      ctrl  <= flush ? '0 : stall ? ctrl : src_ctrl;
      data  <= stall ? data : src_data;
      pc    <= stall ? pc : src_pc;
    end
  // the entry that would have been held valid next cycle is the one a flush destroys
  assign killed = flush && (stall ? valid : src_valid);
endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH-stage pipeline register with flush, stall and saturating event counters.
module pipe_stage_chain
  import pipe_stage_chain_pkg::*;
#(
  parameter int DEPTH  = 1,
  parameter int CTRL_W = 2,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DEPTH-1:0]  flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [PC_W-1:0]   out_pc,
  output logic [DEPTH-1:0]  stage_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
);
  logic [DEPTH-1:0]  v, sv, killed;
  logic [CTRL_W-1:0] c [DEPTH];
  logic [CTRL_W-1:0] sc [DEPTH];
  logic [DATA_W-1:0] d [DEPTH];
  logic [DATA_W-1:0] sd [DEPTH];
  logic [PC_W-1:0]   p [DEPTH];
  logic [PC_W-1:0]   sp [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign sv[k] = in_valid;
      assign sc[k] = in_ctrl;
      assign sd[k] = in_data;
      assign sp[k] = in_pc;
    end else begin : g_body
      assign sv[k] = v[k-1];
      assign sc[k] = c[k-1];
      assign sd[k] = d[k-1];
      assign sp[k] = p[k-1];
    end
    pipe_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_stage (
      .clk(clk),
      .rst(rst),
      .stall(stall),
      .flush(flush[k]),
      .src_valid(sv[k]),
      .src_ctrl(sc[k]),
      .src_data(sd[k]),
      .src_pc(sp[k]),
      .valid(v[k]),
      .ctrl(c[k]),
      .data(d[k]),
      .pc(p[k]),
      .killed(killed[k])
    );
  end
  assign out_valid   = v[DEPTH-1];
  assign out_ctrl    = c[DEPTH-1];
  assign out_data    = d[DEPTH-1];
  assign out_pc      = p[DEPTH-1];
  assign stage_valid = v;
  // four guard bits absorb up to eight kills per cycle before saturating
  localparam logic [CNT_W+3:0] CNT_MAX = {4'd0, {CNT_W{1'b1}}};
  logic [CNT_W+3:0] kill_sum;
  assign kill_sum = {4'd0, kill_cnt} + {{CNT_W{1'b0}}, popcount8(8'(killed))};
  always_ff @(posedge clk)
    if (rst || cnt_clr) begin
      stall_cnt <= '0;
      kill_cnt  <= '0;
    end else begin
      stall_cnt <= stall_cnt + ((stall && stall_cnt != '1) ? CNT_W'(1) : '0);
      kill_cnt  <= kill_sum > CNT_MAX ? '1 : kill_sum[CNT_W-1:0];
    end
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed and randomized checks of pipe_stage_chain against a stage-array model.
module tb_pipe_stage_chain;
  localparam int D = 3, CW = 2, DW = 32, NW = 4, PW = 16;
  localparam int CMAX = 15;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, cnt_clr = 1'b0, in_valid = 1'b0;
  logic [D-1:0] flush = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic [PW-1:0] in_pc = '0;
  logic out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_pc;
  logic [D-1:0] stage_valid;
  logic [NW-1:0] stall_cnt, kill_cnt;

  pipe_stage_chain #(.DEPTH(D), .CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data), .in_pc(in_pc),
    .out_valid(out_valid), .out_ctrl(out_ctrl), .out_data(out_data), .out_pc(out_pc),
    .stage_valid(stage_valid), .stall_cnt(stall_cnt), .kill_cnt(kill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic [CW-1:0] c;
    logic [DW-1:0] d;
    logic [PW-1:0] p;
  } ent_t;

  ent_t m [D];
  int ms = 0, mk = 0;
  int vecs = 0, errs = 0;
  bit live = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: each stage's next entry follows the priority rst > flush > stall > advance
  task automatic cyc();
    ent_t nx [D];
    ent_t src;
    int kills;
    int nms, nmk;
    kills = 0;
    for (int k = 0; k < D; k++) begin
      if (k == 0) src = {in_valid, in_ctrl, in_data, in_pc};
      else src = m[k-1];
      nx[k] = stall ? m[k] : src;
      if (flush[k]) begin
        kills += int'(nx[k].v);
        nx[k].v = 1'b0;
        nx[k].c = '0;
      end
    end
    nms = (ms + int'(stall) > CMAX) ? CMAX : ms + int'(stall);
    nmk = (mk + kills > CMAX) ? CMAX : mk + kills;
    if (rst) begin
      for (int k = 0; k < D; k++) nx[k] = '0;
    end
    if (rst || cnt_clr) begin
      nms = 0;
      nmk = 0;
    end
    @(posedge clk);
    m = nx;
    ms = nms;
    mk = nmk;
    #1;
  endtask

  task automatic put(input bit v, input logic [PW-1:0] pc);
    in_valid = v;
    in_pc = pc;
    in_data = {pc, ~pc};
    in_ctrl = {v, pc[1]};
    cyc();
  endtask

  always @(negedge clk)
    if (live) begin
      chk("out_valid", 64'(out_valid), 64'(m[D-1].v));
      chk("out_ctrl", 64'(out_ctrl), 64'(m[D-1].c));
      chk("out_data", 64'(out_data), 64'(m[D-1].d));
      chk("out_pc", 64'(out_pc), 64'(m[D-1].p));
      chk("stage_valid", 64'(stage_valid), 64'({m[2].v, m[1].v, m[0].v}));
      chk("stall_cnt", 64'(stall_cnt), 64'(ms));
      chk("kill_cnt", 64'(kill_cnt), 64'(mk));
    end

  initial begin
    for (int k = 0; k < D; k++) m[k] = '0;
    rst = 1'b1;
    cyc();
    live = 1'b1;
    cyc();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    put(1'b1, 16'h0010);
    put(1'b1, 16'h0012);
    put(1'b1, 16'h0014);
    chk("stream_pc0", 64'(out_pc), 64'h0010);
    chk("stream_v0", 64'(out_valid), 64'd1);
    put(1'b0, 16'h0000);
    chk("stream_pc1", 64'(out_pc), 64'h0012);
    put(1'b0, 16'h0000);
    chk("stream_pc2", 64'(out_pc), 64'h0014);
    chk("stream_stall_cnt", 64'(stall_cnt), 64'd0);
    put(1'b0, 16'h0000);
    put(1'b1, 16'h0030);
    stall = 1'b1;
    put(1'b0, 16'h0000);
    put(1'b0, 16'h0000);
    stall = 1'b0;
    put(1'b0, 16'h0000);
    chk("stall_lat4_v", 64'(out_valid), 64'd0);
    put(1'b0, 16'h0000);
    chk("stall_lat5_pc", 64'(out_pc), 64'h0030);
    chk("stall_lat5_v", 64'(out_valid), 64'd1);
    chk("stall_cnt2", 64'(stall_cnt), 64'd2);
    put(1'b0, 16'h0000);
    put(1'b0, 16'h0000);
    put(1'b1, 16'h0040);
    flush = 3'b010;
    put(1'b0, 16'h0000);
    flush = '0;
    chk("flush_adv_sv", 64'(stage_valid), 64'b000);
    chk("flush_adv_kill", 64'(kill_cnt), 64'd1);
    flush = 3'b010;
    put(1'b0, 16'h0000);
    flush = '0;
    chk("flush_empty_kill", 64'(kill_cnt), 64'd1);
    put(1'b1, 16'h0050);
    put(1'b1, 16'h0052);
    put(1'b1, 16'h0054);
    chk("fill_sv", 64'(stage_valid), 64'b111);
    stall = 1'b1;
    flush = 3'b101;
    put(1'b1, 16'h0056);
    stall = 1'b0;
    flush = '0;
    chk("flush_stall_sv", 64'(stage_valid), 64'b010);
    chk("flush_stall_kill", 64'(kill_cnt), 64'd3);
    chk("flush_stall_scnt", 64'(stall_cnt), 64'd3);
    stall = 1'b1;
    repeat (20) put(1'b0, 16'h0000);
    chk("sat_stall_cnt", 64'(stall_cnt), 64'd15);
    cnt_clr = 1'b1;
    put(1'b0, 16'h0000);
    cnt_clr = 1'b0;
    stall = 1'b0;
    chk("clr_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("clr_kill_cnt", 64'(kill_cnt), 64'd0);
    flush = 3'b001;
    put(1'b1, 16'h0060);
    flush = '0;
    chk("kill_before_rst", 64'(kill_cnt), 64'd1);
    put(1'b1, 16'h0062);
    put(1'b1, 16'h0064);
    put(1'b1, 16'h0066);
    chk("refill_sv", 64'(stage_valid), 64'b111);
    rst = 1'b1;
    flush = 3'b111;
    put(1'b1, 16'h0068);
    rst = 1'b0;
    flush = '0;
    chk("rst_mid_sv", 64'(stage_valid), 64'd0);
    chk("rst_mid_pc", 64'(out_pc), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    chk("rst_mid_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_mid_kill", 64'(kill_cnt), 64'd0);
    chk("rst_mid_scnt", 64'(stall_cnt), 64'd0);
    repeat (3000) begin
      rst = $urandom_range(0, 199) == 0;
      cnt_clr = $urandom_range(0, 99) == 0;
      stall = $urandom_range(0, 3) == 0;
      for (int k = 0; k < D; k++) flush[k] = $urandom_range(0, 9) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_ctrl = CW'($urandom);
      in_data = $urandom;
      in_pc = PW'($urandom);
      cyc();
    end
    live = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
